// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  // Counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int unsigned piso_cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit down-counter for piso_stream: load, decrement-on-enable, flags the last bit.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_d;

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clr) begin
      w_cnt_d = '0;
    end else if (i_load) begin
      w_cnt_d = i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      w_cnt_d = r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with valid/ready input, per-word bit order
// and gapless back-to-back operation.
module piso_stream
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             lsb_first,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = piso_cnt_w(WIDTH);

  piso_state_t      r_state, w_state_d;
  logic [WIDTH-1:0] r_shreg, w_shreg_d;
  logic             r_lsb, w_lsb_d;
  logic             r_ser, w_ser_d;
  logic             r_done, w_done_d;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_last;
  logic             w_accept;

  piso_bit_cnt #(
    .CNT_W(CNT_W)
  ) u_bit_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clr     (clear),
    .i_load    (w_cnt_load),
    .i_load_val(CNT_W'(WIDTH)),
    .i_dec     (w_cnt_dec),
    .o_last    (w_last)
  );

  // w_last can only be true in SHIFT, so this also covers the gapless reload slot.
  assign in_ready = !clear && ((r_state == IDLE) || (w_last && shift_en));
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_d  = r_state;
    w_shreg_d  = r_shreg;
    w_lsb_d    = r_lsb;
    w_ser_d    = r_ser;
    w_done_d   = 1'b0;
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    if (clear) begin
      w_state_d = IDLE;
      w_ser_d   = IDLE_LEVEL;
    end else if (w_accept) begin
      w_state_d  = SHIFT;
      w_shreg_d  = in_data;
      w_lsb_d    = lsb_first;
      w_ser_d    = lsb_first ? in_data[0] : in_data[WIDTH-1];
      w_cnt_load = 1'b1;
      // Accepting while in SHIFT means the previous word's last bit was just consumed.
      w_done_d   = (r_state == SHIFT);
    end else if ((r_state == SHIFT) && shift_en) begin
      w_cnt_dec = 1'b1;
      if (w_last) begin
        w_done_d  = 1'b1;
        w_state_d = IDLE;
        w_ser_d   = IDLE_LEVEL;
      end else if (r_lsb) begin
        w_shreg_d = {IDLE_LEVEL, r_shreg[WIDTH-1:1]};
        w_ser_d   = r_shreg[1];
      end else begin
        w_shreg_d = {r_shreg[WIDTH-2:0], IDLE_LEVEL};
        w_ser_d   = r_shreg[WIDTH-2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_lsb   <= 1'b0;
      r_ser   <= IDLE_LEVEL;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shreg <= w_shreg_d;
      r_lsb   <= w_lsb_d;
      r_ser   <= w_ser_d;
      r_done  <= w_done_d;
    end
  end

  assign ser_out = r_ser;
  assign busy    = (r_state == SHIFT);
  assign done    = r_done;

endmodule

// File: tb/tb_piso_stream.sv
// Directed self-checking bench for piso_stream (WIDTH=8, IDLE_LEVEL=1).
module tb_piso_stream;

  logic       clk;
  logic       reset_n;
  logic       clear;
  logic       shift_en;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       lsb_first;
  logic       ser_out;
  logic       busy;
  logic       done;

  int errors;
  int checks;

  piso_stream #(
    .WIDTH     (8),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .shift_en (shift_en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .lsb_first(lsb_first),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    clear     = 1'b0;
    shift_en  = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    lsb_first = 1'b0;
    #12;
    checks++;
    if (ser_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: got ser=%b busy=%b done=%b want 1 0 0", ser_out, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (ser_out !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL idle_cyc%0d: got ser=%b busy=%b rdy=%b done=%b want 1 0 1 0",
                 k, ser_out, busy, in_ready, done);
      end
      tick();
    end
  endtask

  task automatic test_msb_a5();
    logic [7:0] w;
    w         = 8'hA5;
    shift_en  = 1'b1;
    in_valid  = 1'b1;
    in_data   = w;
    lsb_first = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL a5_ready: got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out !== w[7-i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL a5_bit%0d: got ser=%b busy=%b done=%b want %b 1 0",
                 i, ser_out, busy, done, w[7-i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || ser_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL a5_end: got done=%b ser=%b busy=%b want 1 1 0", done, ser_out, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || ser_out !== 1'b1) begin
      errors++;
      $display("FAIL a5_after: got done=%b ser=%b want 0 1", done, ser_out);
    end
  endtask

  task automatic test_lsb_slow();
    logic [7:0] w;
    w         = 8'h01;
    shift_en  = 1'b0;
    in_valid  = 1'b1;
    in_data   = w;
    lsb_first = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_data   = 8'hFF;
    lsb_first = 1'b0;
    for (int k = 0; k < 32; k++) begin
      shift_en = ((k % 4) == 3);
      checks++;
      if (ser_out !== w[k/4] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL lsb_cyc%0d: got ser=%b busy=%b done=%b want %b 1 0",
                 k, ser_out, busy, done, w[k/4]);
      end
      tick();
    end
    shift_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || ser_out !== 1'b1) begin
      errors++;
      $display("FAIL lsb_end: got busy=%b done=%b ser=%b want 0 1 1", busy, done, ser_out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    shift_en  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    lsb_first = 1'b0;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out !== 1'b1 || busy !== 1'b1 || in_ready !== (i == 7) || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_w0_bit%0d: got ser=%b busy=%b rdy=%b done=%b want 1 1 %b 0",
                 i, ser_out, busy, in_ready, done, (i == 7));
      end
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out !== 1'b0 || busy !== 1'b1 || done !== (i == 0)) begin
        errors++;
        $display("FAIL b2b_w1_bit%0d: got ser=%b busy=%b done=%b want 0 1 %b",
                 i, ser_out, busy, done, (i == 0));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || ser_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got done=%b ser=%b busy=%b want 1 1 0", done, ser_out, busy);
    end
    tick();
  endtask

  task automatic test_clear();
    logic [7:0] w;
    shift_en  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h0F;
    lsb_first = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    checks++;
    if (in_ready !== 1'b0 || ser_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre: got rdy=%b ser=%b busy=%b want 0 0 1", in_ready, ser_out, busy);
    end
    tick();
    clear = 1'b0;
    checks++;
    if (ser_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL clr_post: got ser=%b busy=%b done=%b want 1 0 0", ser_out, busy, done);
    end
    w = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out !== w[7-i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL clr_new_bit%0d: got ser=%b busy=%b done=%b want %b 1 0",
                 i, ser_out, busy, done, w[7-i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_new_end: got done=%b busy=%b want 1 0", done, busy);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    shift_en  = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    lsb_first = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1 || ser_out !== 1'b0) begin
      errors++;
      $display("FAIL arst_pre: got busy=%b ser=%b want 1 0", busy, ser_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ser_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL arst_now: got ser=%b busy=%b done=%b want 1 0 0", ser_out, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_rel: got busy=%b done=%b rdy=%b want 0 0 1", busy, done, in_ready);
    end
    w         = 8'h80;
    in_valid  = 1'b1;
    in_data   = w;
    lsb_first = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ser_out !== w[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL arst_new_bit%0d: got ser=%b busy=%b done=%b want %b 1 0",
                 i, ser_out, busy, done, w[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || ser_out !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_new_end: got done=%b ser=%b busy=%b want 1 1 0", done, ser_out, busy);
    end
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_msb_a5();
    test_lsb_slow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out serializer for the serial-link datapath.
- Accepts WIDTH-bit words through a valid/ready handshake and shifts them out one bit per `shift_en` tick, MSB- or LSB-first, selected per word.
- Drives the line to IDLE_LEVEL when no word is in flight and reports frame completion.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- IDLE_LEVEL, 1, `ser_out` value when idle and in reset.
- CNT_W, $clog2(WIDTH+1), bit-counter width. This is a localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous abort; drops the word in flight
- shift_en  in  1  bit-rate tick; one serial bit is consumed per asserted cycle
- in_valid  in  1  `in_data` and `lsb_first` are valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  parallel word
- lsb_first  in  1  bit order for the word; sampled at accept only
- ser_out  out  1  registered serial output
- busy  out  1  a word is in flight
- done  out  1  one-cycle pulse when the last bit of a word has been consumed

Behaviour:
- Reset is asynchronous and active-low on `reset_n`; `clk` is the only clock.
- Reset values:
  - state = IDLE
  - ser_out = IDLE_LEVEL
  - busy = 0, done = 0
  - bit counter = 0
  - shift register = 0
- The FSM has two states, IDLE and SHIFT. `busy` = (state == SHIFT).
- in_ready is combinational: `!clear && (state == IDLE || (cnt == 1 && shift_en))`.
- Accept occurs when `in_valid && in_ready`. On accept:
  - The shift register loads `in_data` and the bit order is latched from `lsb_first`.
  - cnt = WIDTH.
  - The first bit (in_data[WIDTH-1], or in_data[0] when lsb_first) appears on `ser_out` the cycle after accept. Latency is 1 clk.
- SHIFT state, on a cycle with `shift_en` = 1:
  - If cnt > 1: present the next bit on `ser_out` and decrement cnt.
  - If cnt == 1: the last bit has been consumed and `done` = 1 on the next cycle.
    - If a word is accepted in the same cycle, reload, stay in SHIFT, and present its first bit next cycle (gapless).
    - Otherwise go to IDLE with ser_out = IDLE_LEVEL.
- SHIFT state, on a cycle with `shift_en` = 0: all state holds and each bit remains on `ser_out` until its tick.
- `shift_en` in IDLE, including on the accept cycle, is ignored. Bit 1 is consumed by the first tick strictly after the accept cycle.
- Bits shifted in behind the data are IDLE_LEVEL. They are never visible, because the state leaves SHIFT first.
- `clear` = 1 has priority over everything except reset:
  - Next cycle: state = IDLE, ser_out = IDLE_LEVEL, cnt = 0.
  - No `done` pulse and no accept in that cycle.
- `in_valid` without `in_ready` is held by the source. `in_data` is ignored until accept.
- Async reset mid-word aborts immediately: `ser_out` goes to IDLE_LEVEL at once and no `done` is produced.
- `done` and an accept may coincide on the cycle after the last tick. This is legal and has no effect on either.

Decomposition:
- Package `piso_pkg`:
  - state enum `piso_state_t` {IDLE, SHIFT}
  - localparam helper function for CNT_W
- One sub-module, `piso_bit_cnt`:
  - Down-counter with load and decrement-on-enable.
  - Outputs `last` = (cnt == 1).
  - Same asynchronous active-low reset.
- The FSM, shift register and output register stay in `piso_stream`.

Test Plan:
- Reset, then `shift_en` held 1 and no `in_valid` -> ser_out = 1, busy = 0, in_ready = 1, done = 0 for 20 cycles.
- WIDTH=8, accept 8'hA5 with lsb_first=0 and `shift_en` every cycle -> ser_out = 1,0,1,0,0,1,0,1 starting 1 clk after accept; done pulses once 1 clk after the 8th bit is consumed; then ser_out = 1.
- Accept 8'h01 with lsb_first=1 and `shift_en` every 4th cycle -> each bit is held exactly 4 cycles; sequence is 1,0,0,0,0,0,0,0; busy is high for 32 cycles.
- Back-to-back: `in_valid` held high with 8'hFF then 8'h00 -> in_ready pulses only on the last-bit tick; 16 consecutive data bits with no idle gap; two done pulses.
- `clear` asserted after 3 bits of 8'h0F -> next cycle ser_out = 1, busy = 0, no done; a new word accepted afterwards serializes correctly.
- `reset_n` dropped mid-word, asynchronously between clock edges -> ser_out = 1 and busy = 0 immediately; no done; normal operation after release.
